ext_mem_axi_arb: RTL and testbench

N-master native-bus to AXI4 bridge for the external-memory subsystem. It replaces fixed two-master merge-then-L2 wiring with a parametrised round-robin arbiter. It sits between the cache back-ends (any count) and the DDR controller AXI port. Each granted request becomes one single-beat AXI read or write, returned to the requesting master.

---
 rtl/ext_mem_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 24 ++
 rtl/ext_mem_axi_arb.sv | 204 ++++++++++++++++++++
 tb/tb_ext_mem_axi_arb.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// Shared types and AXI constants for the external-memory AXI bridge.
// Optional error counter is enabled by defining EXT_MEM_ERR_CNT_EN.
package ext_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW_W,
    ST_B,
    ST_DONE
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] CACHE_DEF  = 4'b0011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic logic [2:0] axi_size(input int dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
// Used by ext_mem_axi_arb (EXT_MEM_ERR_CNT_EN has no effect here).
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt,
  output logic          any_req
);

  always_comb begin
    gnt     = '0;
    any_req = |req;
    // Walk offsets high to low so the nearest requester wins last.
    for (int off = N - 1; off >= 0; off--) begin
      automatic int j = int'(ptr) + off;
      if (j >= N) j = j - N;
      if (req[j]) gnt = IW'(j);
    end
  end

endmodule

// File: rtl/ext_mem_axi_arb.sv
// N-master native bus to single-beat AXI4 bridge with round-robin grant.
// Define EXT_MEM_ERR_CNT_EN to enable the non-OKAY response counter.
module ext_mem_axi_arb
  import ext_mem_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int AXI_ID_W  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
  output logic [N_MASTERS*DATA_W-1:0] m_rdata,
  output logic [N_MASTERS-1:0]        m_ready,
  output logic [AXI_ID_W-1:0]         axi_awid,
  output logic [ADDR_W-1:0]           axi_awaddr,
  output logic [7:0]                  axi_awlen,
  output logic [2:0]                  axi_awsize,
  output logic [1:0]                  axi_awburst,
  output logic                        axi_awlock,
  output logic [3:0]                  axi_awcache,
  output logic [2:0]                  axi_awprot,
  output logic [3:0]                  axi_awqos,
  output logic                        axi_awvalid,
  input  logic                        axi_awready,
  output logic [DATA_W-1:0]           axi_wdata,
  output logic [DATA_W/8-1:0]         axi_wstrb,
  output logic                        axi_wlast,
  output logic                        axi_wvalid,
  input  logic                        axi_wready,
  input  logic [AXI_ID_W-1:0]         axi_bid,
  input  logic [1:0]                  axi_bresp,
  input  logic                        axi_bvalid,
  output logic                        axi_bready,
  output logic [AXI_ID_W-1:0]         axi_arid,
  output logic [ADDR_W-1:0]           axi_araddr,
  output logic [7:0]                  axi_arlen,
  output logic [2:0]                  axi_arsize,
  output logic [1:0]                  axi_arburst,
  output logic                        axi_arlock,
  output logic [3:0]                  axi_arcache,
  output logic [2:0]                  axi_arprot,
  output logic [3:0]                  axi_arqos,
  output logic                        axi_arvalid,
  input  logic                        axi_arready,
  input  logic [AXI_ID_W-1:0]         axi_rid,
  input  logic [DATA_W-1:0]           axi_rdata,
  input  logic [1:0]                  axi_rresp,
  input  logic                        axi_rlast,
  input  logic                        axi_rvalid,
  output logic                        axi_rready,
  output logic [15:0]                 err_cnt,
  input  logic                        err_clr
);

  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int SW = DATA_W / 8;

  state_e              state, state_n;
  logic [IW-1:0]       idx, ptr, gnt;
  logic                any_req;
  logic [ADDR_W-3:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [SW-1:0]       wstrb_q, wstrb_sel;
  logic                aw_done, w_done;

  rr_arbiter #(.N(N_MASTERS), .IW(IW)) u_arb (
    .req     (m_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .any_req (any_req)
  );

  assign wstrb_sel = m_wstrb[gnt*SW +: SW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      ptr     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        ST_IDLE: if (any_req) begin
          idx     <= gnt;
          addr_q  <= m_addr[gnt*ADDR_W+2 +: ADDR_W-2];
          wdata_q <= m_wdata[gnt*DATA_W +: DATA_W];
          wstrb_q <= wstrb_sel;
          rdata_q <= '0;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        ST_R: if (axi_rvalid) rdata_q <= axi_rdata;
        ST_AW_W: begin
          if (axi_awready) aw_done <= 1'b1;
          if (axi_wready)  w_done  <= 1'b1;
        end
        ST_DONE: ptr <= (idx == IW'(N_MASTERS - 1)) ? '0 : idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n     = state;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    m_ready     = '0;
    m_rdata     = '0;
    unique case (state)
      ST_IDLE: if (any_req) state_n = (wstrb_sel == '0) ? ST_AR : ST_AW_W;
      ST_AR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) state_n = ST_R;
      end
      ST_R: begin
        axi_rready = 1'b1;
        if (axi_rvalid) state_n = ST_DONE;
      end
      ST_AW_W: begin
        axi_awvalid = !aw_done;
        axi_wvalid  = !w_done;
        if ((aw_done || axi_awready) && (w_done || axi_wready))
          state_n = ST_B;
      end
      ST_B: begin
        axi_bready = 1'b1;
        if (axi_bvalid) state_n = ST_DONE;
      end
      ST_DONE: begin
        m_ready[idx]                 = 1'b1;
        m_rdata[idx*DATA_W +: DATA_W] = rdata_q;
        state_n                      = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign axi_awid    = AXI_ID_W'(idx);
  assign axi_awaddr  = {addr_q, 2'b00};
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = axi_size(DATA_W);
  assign axi_awburst = BURST_INCR;
  assign axi_awlock  = 1'b0;
  assign axi_awcache = CACHE_DEF;
  assign axi_awprot  = 3'b000;
  assign axi_awqos   = 4'd0;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wlast   = 1'b1;
  assign axi_arid    = AXI_ID_W'(idx);
  assign axi_araddr  = {addr_q, 2'b00};
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = axi_size(DATA_W);
  assign axi_arburst = BURST_INCR;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = CACHE_DEF;
  assign axi_arprot  = 3'b000;
  assign axi_arqos   = 4'd0;

`ifdef EXT_MEM_ERR_CNT_EN
  logic        err_hit;
  logic [15:0] err_q;

  assign err_hit =
    (state == ST_R && axi_rvalid && axi_rresp != RESP_OKAY) ||
    (state == ST_B && axi_bvalid && axi_bresp != RESP_OKAY);

  // Clear takes priority over a coincident error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= '0;
    else if (err_clr)
      err_q <= '0;
    else if (err_hit && err_q != 16'hFFFF)
      err_q <= err_q + 16'd1;
  end

  assign err_cnt = err_q;

  logic unused_ok;
  assign unused_ok = ^{axi_bid, axi_rid, axi_rlast};
`else
  assign err_cnt = '0;

  logic unused_ok;
  assign unused_ok = ^{axi_bid, axi_rid, axi_rlast,
                       axi_rresp, axi_bresp, err_clr};
`endif

endmodule

// File: tb/tb_ext_mem_axi_arb.sv
// Directed self-checking bench for ext_mem_axi_arb with three masters.
// Error-count expectations follow EXT_MEM_ERR_CNT_EN.
module tb_ext_mem_axi_arb;

  localparam int N   = 3;
  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int IDW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]      m_valid;
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_wdata;
  logic [N*DW/8-1:0] m_wstrb;
  logic [N*DW-1:0]   m_rdata;
  logic [N-1:0]      m_ready;
  logic [IDW-1:0]    axi_awid, axi_bid, axi_arid, axi_rid;
  logic [AW-1:0]     axi_awaddr, axi_araddr;
  logic [7:0]        axi_awlen, axi_arlen;
  logic [2:0]        axi_awsize, axi_arsize, axi_awprot, axi_arprot;
  logic [1:0]        axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic              axi_awlock, axi_arlock;
  logic [3:0]        axi_awcache, axi_arcache, axi_awqos, axi_arqos;
  logic              axi_awvalid, axi_awready, axi_wlast, axi_wvalid;
  logic              axi_wready, axi_bvalid, axi_bready;
  logic              axi_arvalid, axi_arready;
  logic              axi_rlast, axi_rvalid, axi_rready;
  logic [DW-1:0]     axi_wdata, axi_rdata;
  logic [DW/8-1:0]   axi_wstrb;
  logic [15:0]       err_cnt;
  logic              err_clr;

  int errs = 0;
  int checks = 0;

  ext_mem_axi_arb #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .AXI_ID_W(IDW)
  ) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
    .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
    .axi_awqos(axi_awqos), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
    .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
    .axi_arqos(axi_arqos), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .err_cnt(err_cnt), .err_clr(err_clr)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic serve_read(input int id, input logic [31:0] d,
                            input logic [1:0] resp, input logic clr);
    logic [N-1:0]    er;
    logic [N*DW-1:0] ed;
    int n;
    n = 0;
    while (!axi_arvalid && n < 20) begin
      cyc();
      n++;
    end
    chk("rd_timeout", 128'(n < 20), 128'(1));
    chk("rd_arid", axi_arid, id);
    axi_arready = 1'b1;
    cyc();
    axi_arready = 1'b0;
    chk("rd_rready", axi_rready, 1'b1);
    axi_rvalid = 1'b1;
    axi_rdata  = d;
    axi_rresp  = resp;
    err_clr    = clr;
    cyc();
    axi_rvalid = 1'b0;
    err_clr    = 1'b0;
    er = '0;
    er[id] = 1'b1;
    ed = '0;
    ed[id*DW +: DW] = d;
    chk("rd_m_ready", m_ready, er);
    chk("rd_m_rdata", m_rdata, ed);
  endtask

  task automatic serve_write(input int id, input logic [1:0] resp);
    logic [N-1:0] er;
    int n;
    n = 0;
    while (!axi_awvalid && n < 20) begin
      cyc();
      n++;
    end
    chk("wr_timeout", 128'(n < 20), 128'(1));
    chk("wr_awid", axi_awid, id);
    axi_awready = 1'b1;
    axi_wready  = 1'b1;
    cyc();
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    chk("wr_bready", axi_bready, 1'b1);
    axi_bvalid = 1'b1;
    axi_bresp  = resp;
    cyc();
    axi_bvalid = 1'b0;
    er = '0;
    er[id] = 1'b1;
    chk("wr_m_ready", m_ready, er);
    chk("wr_m_rdata", m_rdata, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ord [6] = '{2, 0, 1, 2, 0, 1};
    rst = 1'b1;
    m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
    axi_bresp = 0; axi_bid = 0;
    axi_arready = 0; axi_rvalid = 0; axi_rdata = 0;
    axi_rresp = 0; axi_rid = 0; axi_rlast = 1'b1;
    err_clr = 0;
    cyc(); cyc();

    chk("rst_m_ready", m_ready, '0);
    chk("rst_m_rdata", m_rdata, '0);
    chk("rst_arvalid", axi_arvalid, 1'b0);
    chk("rst_awvalid", axi_awvalid, 1'b0);
    chk("rst_wvalid", axi_wvalid, 1'b0);
    chk("rst_bready", axi_bready, 1'b0);
    chk("rst_rready", axi_rready, 1'b0);
    chk("rst_err_cnt", err_cnt, 16'd0);
    rst = 1'b0;

    // Single read, master 0
    m_valid = 3'b001;
    m_addr[29:0] = 30'h104;
    axi_arready = 1'b1;
    cyc();
    chk("r0_arvalid", axi_arvalid, 1'b1);
    chk("r0_araddr", axi_araddr, 30'h104);
    chk("r0_arid", axi_arid, 3'd0);
    chk("r0_arlen", axi_arlen, 8'd0);
    chk("r0_arsize", axi_arsize, 3'd2);
    chk("r0_arburst", axi_arburst, 2'b01);
    chk("r0_arcache", axi_arcache, 4'b0011);
    chk("r0_m_ready_early", m_ready, 3'b000);
    cyc();
    chk("r0_rready", axi_rready, 1'b1);
    chk("r0_arvalid_drop", axi_arvalid, 1'b0);
    axi_rvalid = 1'b1;
    axi_rdata  = 32'hDEADBEEF;
    cyc();
    axi_rvalid = 1'b0;
    axi_arready = 1'b0;
    chk("r0_m_ready", m_ready, 3'b001);
    chk("r0_m_rdata", m_rdata, 96'hDEADBEEF);
    m_valid = '0;
    cyc();
    chk("r0_pulse_once", m_ready, 3'b000);

    // Single write, master 1, awready delayed
    m_valid = 3'b010;
    m_addr[59:30] = 30'h20;
    m_wdata[63:32] = 32'h12345678;
    m_wstrb[7:4] = 4'hF;
    axi_wready = 1'b1;
    cyc();
    chk("w1_awvalid_c1", axi_awvalid, 1'b1);
    chk("w1_wvalid_c1", axi_wvalid, 1'b1);
    chk("w1_awid", axi_awid, 3'd1);
    chk("w1_awaddr", axi_awaddr, 30'h20);
    chk("w1_wdata", axi_wdata, 32'h12345678);
    chk("w1_wstrb", axi_wstrb, 4'hF);
    chk("w1_wlast", axi_wlast, 1'b1);
    cyc();
    chk("w1_wvalid_drop", axi_wvalid, 1'b0);
    chk("w1_awvalid_c2", axi_awvalid, 1'b1);
    cyc();
    chk("w1_awvalid_c3", axi_awvalid, 1'b1);
    axi_awready = 1'b1;
    cyc();
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    chk("w1_awvalid_drop", axi_awvalid, 1'b0);
    chk("w1_bready", axi_bready, 1'b1);
    chk("w1_no_early_ready", m_ready, 3'b000);
    axi_bvalid = 1'b1;
    cyc();
    axi_bvalid = 1'b0;
    chk("w1_m_ready", m_ready, 3'b010);
    chk("w1_m_rdata", m_rdata, '0);
    m_valid = '0;
    m_wstrb = '0;
    cyc();
    chk("w1_pulse_once", m_ready, 3'b000);

    // Reset during R state, master 2 with unaligned address
    m_valid = 3'b100;
    m_addr[89:60] = 30'h3E;
    cyc();
    chk("rs_arid", axi_arid, 3'd2);
    chk("rs_araddr", axi_araddr, 30'h3C);
    axi_arready = 1'b1;
    cyc();
    axi_arready = 1'b0;
    chk("rs_rready", axi_rready, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rs_rready_drop", axi_rready, 1'b0);
    chk("rs_arvalid_drop", axi_arvalid, 1'b0);
    chk("rs_m_ready", m_ready, 3'b000);
    cyc();
    chk("rs_m_ready_hold", m_ready, 3'b000);
    m_valid = 3'b110;
    m_addr[59:30] = 30'h44;
    rst = 1'b0;
    // Pointer back at 0 so master 1 wins over master 2
    serve_read(1, 32'hA5A50001, 2'b00, 1'b0);

    // Round robin with all masters requesting
    m_valid = 3'b111;
    for (int k = 0; k < 6; k++)
      serve_read(ord[k], 32'h1000 + k, 2'b00, 1'b0);

    // Error responses
    m_valid = 3'b001;
    serve_read(0, 32'h000000E0, 2'b10, 1'b0);
    serve_read(0, 32'h000000E1, 2'b10, 1'b0);
    m_wstrb[3:0] = 4'hF;
    serve_write(0, 2'b00);
`ifdef EXT_MEM_ERR_CNT_EN
    chk("err_cnt_two", err_cnt, 16'd2);
`else
    chk("err_cnt_off", err_cnt, 16'd0);
`endif
    m_wstrb = '0;
    serve_read(0, 32'h000000E3, 2'b10, 1'b1);
    chk("err_cnt_clr", err_cnt, 16'd0);
    m_valid = '0;
    cyc(); cyc();
    chk("end_idle", m_ready, 3'b000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
